// File: rtl/fec_pkg.sv
// Shared FEC definitions: rate table, cc_rate encoding and framing byte constants.
// The table lookup lives here so every FEC block decodes rate_id identically.
package fec_pkg;

   localparam int RATE_W      = 4;
   localparam int RATE_ID_MAX = 6;

   localparam logic [7:0] TAIL_BYTE = 8'h00;
   localparam logic [7:0] PAD_BYTE  = 8'hFF;

   typedef enum logic [1:0] {
      CC_1_2 = 2'd0,
      CC_2_3 = 2'd1,
      CC_3_4 = 2'd2,
      CC_5_6 = 2'd3
   } cc_rate_e;

   typedef struct packed {
      logic       valid;
      logic [6:0] k;
      logic [6:0] n;
      logic [2:0] t;
      cc_rate_e   cc;
   } rate_cfg_t;

   // T=8 (rate 3) does not fit the 3-bit field and wraps to 0; N-K still gives 2T.
   function automatic rate_cfg_t rate_lookup(input logic [RATE_W-1:0] id);
      rate_cfg_t c;
      c = '{valid: 1'b0, k: 7'd0, n: 7'd0, t: 3'd0, cc: CC_1_2};
      case (id)
         4'd0:    c = '{valid: 1'b1, k: 7'd12,  n: 7'd12,  t: 3'd0, cc: CC_1_2};
         4'd1:    c = '{valid: 1'b1, k: 7'd24,  n: 7'd32,  t: 3'd4, cc: CC_2_3};
         4'd2:    c = '{valid: 1'b1, k: 7'd36,  n: 7'd40,  t: 3'd2, cc: CC_5_6};
         4'd3:    c = '{valid: 1'b1, k: 7'd48,  n: 7'd64,  t: 3'd0, cc: CC_2_3};
         4'd4:    c = '{valid: 1'b1, k: 7'd72,  n: 7'd80,  t: 3'd4, cc: CC_5_6};
         4'd5:    c = '{valid: 1'b1, k: 7'd96,  n: 7'd108, t: 3'd6, cc: CC_3_4};
         4'd6:    c = '{valid: 1'b1, k: 7'd108, n: 7'd120, t: 3'd6, cc: CC_5_6};
         default: c = '{valid: 1'b0, k: 7'd0,   n: 7'd0,   t: 3'd0, cc: CC_1_2};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fec_rate_lut.sv
// Combinational rate_id decoder: validity plus RS/CC parameters from the shared table.
module fec_rate_lut
   import fec_pkg::*;
(
   input  logic [RATE_W-1:0] rate_id,
   output logic              valid,
   output logic [6:0]        k,
   output logic [6:0]        n,
   output logic [2:0]        t,
   output logic [1:0]        cc_rate
);

   rate_cfg_t cfg;

   always_comb begin
      cfg     = rate_lookup(rate_id);
      valid   = cfg.valid;
      k       = cfg.k;
      n       = cfg.n;
      t       = cfg.t;
      cc_rate = cfg.cc;
   end

endmodule

// File: rtl/fec_ctrl.sv
// Burst sequencer: splits a payload burst into RS blocks, appends the tail byte and
// (with FEC_CTRL_PAD_EN defined) pads the last block with 0xFF to a full K bytes.
module fec_ctrl
   import fec_pkg::*;
#(
   parameter int LEN_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [RATE_W-1:0] rate_id,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sob,
   output logic              out_eob,
   output logic [6:0]        rs_k,
   output logic [6:0]        rs_n,
   output logic [2:0]        rs_t,
   output logic [1:0]        cc_rate,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CFG  = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_TAIL = 3'd3;
`ifdef FEC_CTRL_PAD_EN
   localparam logic [2:0] S_PAD  = 3'd4;
`endif
   localparam logic [2:0] S_LAST = 3'd5;

   logic [2:0]        state;
   logic [RATE_W-1:0] rate_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  pay_cnt;
   logic [6:0]        pos;

   logic [RATE_W-1:0] lut_rate;
   logic              lut_valid;
   logic [6:0]        lut_k;
   logic [6:0]        lut_n;
   logic [2:0]        lut_t;
   logic [1:0]        lut_cc;

   logic              cfg_ok;
   logic              adv;
   logic              blk_end;
   logic              pay_last;
   logic              take_in;
   logic              gen_byte;
   logic              load;
   logic              eob_next;
   logic [7:0]        data_next;

   // One decoder serves both the start-time validity check and the CFG-cycle load.
   assign lut_rate = (state == S_IDLE) ? rate_id : rate_q;

   fec_rate_lut u_lut (
      .rate_id (lut_rate),
      .valid   (lut_valid),
      .k       (lut_k),
      .n       (lut_n),
      .t       (lut_t),
      .cc_rate (lut_cc)
   );

   assign cfg_ok   = lut_valid && (burst_len != '0);
   assign adv      = !out_valid || out_ready;
   assign blk_end  = (pos == rs_k - 7'd1);
   assign pay_last = (pay_cnt == len_q - LEN_W'(1));
   assign busy     = (state != S_IDLE);
   assign in_ready = (state == S_DATA) && adv && (pay_cnt < len_q);
   assign take_in  = in_valid && in_ready;
   assign load     = take_in || gen_byte;

   // Without padding the tail byte always closes a (possibly shortened) block.
`ifdef FEC_CTRL_PAD_EN
   assign gen_byte  = ((state == S_TAIL) || (state == S_PAD)) && adv;
   assign eob_next  = blk_end;
   assign data_next = take_in ? in_data : ((state == S_TAIL) ? TAIL_BYTE : PAD_BYTE);
`else
   assign gen_byte  = (state == S_TAIL) && adv;
   assign eob_next  = blk_end || (state == S_TAIL);
   assign data_next = take_in ? in_data : TAIL_BYTE;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         rate_q    <= '0;
         len_q     <= '0;
         pay_cnt   <= '0;
         pos       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_sob   <= 1'b0;
         out_eob   <= 1'b0;
         rs_k      <= '0;
         rs_n      <= '0;
         rs_t      <= '0;
         cc_rate   <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;

         if (out_valid && out_ready)
            out_valid <= 1'b0;

         // The output register only reloads when empty or being drained, so a stalled byte holds.
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= data_next;
            out_sob   <= (pos == 7'd0);
            out_eob   <= eob_next;
            pos       <= blk_end ? 7'd0 : pos + 7'd1;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     rate_q <= rate_id;
                     len_q  <= burst_len;
                     state  <= S_CFG;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_CFG: begin
               rs_k    <= lut_k;
               rs_n    <= lut_n;
               rs_t    <= lut_t;
               cc_rate <= lut_cc;
               pos     <= '0;
               pay_cnt <= '0;
               state   <= S_DATA;
            end
            S_DATA: begin
               if (take_in) begin
                  pay_cnt <= pay_cnt + LEN_W'(1);
                  if (pay_last)
                     state <= S_TAIL;
               end
            end
            S_TAIL: begin
               if (adv) begin
`ifdef FEC_CTRL_PAD_EN
                  state <= blk_end ? S_LAST : S_PAD;
`else
                  state <= S_LAST;
`endif
               end
            end
`ifdef FEC_CTRL_PAD_EN
            S_PAD: begin
               if (adv && blk_end)
                  state <= S_LAST;
            end
`endif
            S_LAST: begin
               // Stay busy until the final byte actually leaves the output register.
               if (out_valid && out_ready) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fec_ctrl.sv
// Self-checking bench for fec_ctrl: randomized bursts compared against a stream model
// built from the rate table (honours FEC_CTRL_PAD_EN when defined).
module tb_fec_ctrl;

   localparam int LEN_W = 11;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [3:0]       rate_id = '0;
   logic [LEN_W-1:0] burst_len = '0;
   logic [7:0]       in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             out_sob;
   logic             out_eob;
   logic [6:0]       rs_k;
   logic [6:0]       rs_n;
   logic [2:0]       rs_t;
   logic [1:0]       cc_rate;
   logic             busy;
   logic             done;
   logic             err;

   int checks = 0;
   int errors = 0;

   int k_tab  [7] = '{12, 24, 36, 48, 72, 96, 108};
   int n_tab  [7] = '{12, 32, 40, 64, 80, 108, 120};
   int t_tab  [7] = '{0, 4, 2, 8, 4, 6, 6};
   int cc_tab [7] = '{0, 1, 3, 1, 3, 2, 3};

   logic [7:0] payload [$];
   logic [7:0] exp_data [$];
   bit         exp_sob [$];
   bit         exp_eob [$];
   logic [7:0] got_data [$];
   bit         got_sob [$];
   bit         got_eob [$];
   int         done_cnt, extra_taken, stall_err, first_valid_iter;
   bit         timed_out;

   fec_ctrl #(.LEN_W(LEN_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rate_id   (rate_id),
      .burst_len (burst_len),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sob   (out_sob),
      .out_eob   (out_eob),
      .rs_k      (rs_k),
      .rs_n      (rs_n),
      .rs_t      (rs_t),
      .cc_rate   (cc_rate),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Reference stream: payload, one tail byte, optional pad to a block multiple.
   function automatic void build_expected(input int rate, input int len);
      int k;
      int l;
      int total;
      k = k_tab[rate];
      l = len + 1;
`ifdef FEC_CTRL_PAD_EN
      total = ((l + k - 1) / k) * k;
`else
      total = l;
`endif
      exp_data.delete();
      exp_sob.delete();
      exp_eob.delete();
      for (int i = 0; i < total; i++) begin
         exp_data.push_back(i < len ? payload[i] : (i == len ? 8'h00 : 8'hFF));
         exp_sob.push_back((i % k) == 0);
         exp_eob.push_back(((i % k) == k - 1) || (i == total - 1));
      end
   endfunction

   task automatic fill_payload(input int len, input bit counting);
      payload.delete();
      for (int i = 0; i < len; i++)
         payload.push_back(counting ? 8'(i + 1) : 8'($urandom));
   endtask

   task automatic do_start(input logic [3:0] r, input logic [LEN_W-1:0] l);
      start = 1'b1;
      rate_id = r;
      burst_len = l;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Drives payload / out_ready and records every downstream handshake; compares nothing.
   task automatic drive_burst(input int len, input bit rand_ready, input bit rand_valid,
                              input int stop_after, input bit chain,
                              input logic [3:0] next_rate, input logic [LEN_W-1:0] next_len);
      int src_idx = 0;
      int iter = 0;
      int post_done = -1;
      bit prev_stall = 1'b0;
      logic [7:0] prev_data = '0;
      logic prev_sob = 1'b0;
      logic prev_eob = 1'b0;
      got_data.delete();
      got_sob.delete();
      got_eob.delete();
      done_cnt = 0;
      extra_taken = 0;
      stall_err = 0;
      timed_out = 1'b0;
      first_valid_iter = -1;
      while (1) begin
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (src_idx < len) begin
            in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = payload[src_idx];
         end else begin
            in_valid = 1'b1;
            in_data  = 8'hEE;
         end
         #2;
         if (prev_stall && (!out_valid || out_data !== prev_data ||
                            out_sob !== prev_sob || out_eob !== prev_eob))
            stall_err++;
         if (out_valid && first_valid_iter < 0)
            first_valid_iter = iter;
         if (in_valid && in_ready) begin
            if (src_idx < len) src_idx++;
            else extra_taken++;
         end
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_sob.push_back(out_sob);
            got_eob.push_back(out_eob);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_sob   = out_sob;
         prev_eob   = out_eob;
         if (done) begin
            done_cnt++;
            if (chain) begin
               in_valid  = 1'b0;
               start     = 1'b1;
               rate_id   = next_rate;
               burst_len = next_len;
               return;
            end
            if (post_done < 0) post_done = iter;
         end
         if (stop_after > 0 && got_data.size() >= stop_after) break;
         if (post_done >= 0 && iter >= post_done + 3) break;
         if (iter >= 3000) begin
            timed_out = 1'b1;
            break;
         end
         iter++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_sob, out_eob, busy, in_ready, done, err} !== 7'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 0000000",
                  {out_valid, out_sob, out_eob, busy, in_ready, done, err});
      end
      checks++;
      if ({out_data, rs_k, rs_n, rs_t, cc_rate} !== 27'b0) begin
         errors++;
         $display("[TB] FAIL reset_values: got %h expected 0", {out_data, rs_k, rs_n, rs_t, cc_rate});
      end
      reset = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_rate1();
      fill_payload(46, 1'b1);
      build_expected(1, 46);
      do_start(4'd1, 11'd46);
      drive_burst(46, 1'b0, 1'b0, 0, 1'b0, 4'd0, '0);
      checks++;
      if (got_data.size() != exp_data.size()) begin
         errors++;
         $display("[TB] FAIL rate1_len: got %0d bytes expected %0d", got_data.size(), exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_data[i] || got_sob[i] !== exp_sob[i] || got_eob[i] !== exp_eob[i]) begin
            errors++;
            $display("[TB] FAIL rate1_byte%0d: got %h/%b/%b expected %h/%b/%b", i,
                     got_data[i], got_sob[i], got_eob[i], exp_data[i], exp_sob[i], exp_eob[i]);
         end
      end
      checks++;
      if (first_valid_iter != 2) begin
         errors++;
         $display("[TB] FAIL rate1_latency: got %0d expected 2", first_valid_iter);
      end
      checks++;
      if ({rs_k, rs_n, rs_t, cc_rate} !== {7'(k_tab[1]), 7'(n_tab[1]), 3'(t_tab[1]), 2'(cc_tab[1])}) begin
         errors++;
         $display("[TB] FAIL rate1_cfg: got k%0d n%0d t%0d cc%0d expected k%0d n%0d t%0d cc%0d",
                  rs_k, rs_n, rs_t, cc_rate, k_tab[1], n_tab[1], t_tab[1], cc_tab[1]);
      end
      checks++;
      if (timed_out || done_cnt != 1 || extra_taken != 0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rate1_done: got done%0d extra%0d timeout%0d busy%b expected 1 0 0 0",
                  done_cnt, extra_taken, timed_out, busy);
      end
   endtask

   task automatic test_rate0();
      fill_payload(11, 1'b0);
      build_expected(0, 11);
      do_start(4'd0, 11'd11);
      drive_burst(11, 1'b0, 1'b1, 0, 1'b0, 4'd0, '0);
      checks++;
      if (got_data.size() != exp_data.size()) begin
         errors++;
         $display("[TB] FAIL rate0_len: got %0d bytes expected %0d", got_data.size(), exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_data[i] || got_sob[i] !== exp_sob[i] || got_eob[i] !== exp_eob[i]) begin
            errors++;
            $display("[TB] FAIL rate0_byte%0d: got %h/%b/%b expected %h/%b/%b", i,
                     got_data[i], got_sob[i], got_eob[i], exp_data[i], exp_sob[i], exp_eob[i]);
         end
      end
      checks++;
      if (timed_out || done_cnt != 1 || rs_k !== 7'(k_tab[0]) || rs_n !== 7'(n_tab[0])) begin
         errors++;
         $display("[TB] FAIL rate0_done: got done%0d timeout%0d k%0d n%0d expected 1 0 %0d %0d",
                  done_cnt, timed_out, rs_k, rs_n, k_tab[0], n_tab[0]);
      end
   endtask

   task automatic test_err();
      in_valid = 1'b1;
      in_data  = 8'hEE;
      do_start(4'd9, 11'd5);
      checks++;
      if ({err, busy, in_ready} !== 3'b100 || rs_k !== 7'(k_tab[0])) begin
         errors++;
         $display("[TB] FAIL err_rate: got err%b busy%b rdy%b k%0d expected 1 0 0 %0d",
                  err, busy, in_ready, rs_k, k_tab[0]);
      end
      @(posedge clk); #1;
      checks++;
      if ({err, busy} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL err_pulse: got err%b busy%b expected 0 0", err, busy);
      end
      do_start(4'd2, 11'd0);
      checks++;
      if ({err, busy, in_ready} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL err_len0: got err%b busy%b rdy%b expected 1 0 0", err, busy, in_ready);
      end
      in_valid = 1'b0;
      fill_payload(3, 1'b0);
      build_expected(1, 3);
      do_start(4'd1, 11'd3);
      do_start(4'd9, 11'd5);
      checks++;
      if ({err, busy} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL err_busy_start: got err%b busy%b expected 0 1", err, busy);
      end
      drive_burst(3, 1'b0, 1'b0, 0, 1'b0, 4'd0, '0);
      checks++;
      if (got_data.size() != exp_data.size() || timed_out || done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL err_short_burst: got %0d bytes done%0d expected %0d bytes done1",
                  got_data.size(), done_cnt, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_data[i] || got_eob[i] !== exp_eob[i]) begin
            errors++;
            $display("[TB] FAIL err_short_byte%0d: got %h/%b expected %h/%b", i,
                     got_data[i], got_eob[i], exp_data[i], exp_eob[i]);
         end
      end
   endtask

   task automatic test_random_stall();
      fill_payload(200, 1'b0);
      build_expected(6, 200);
      do_start(4'd6, 11'd200);
      drive_burst(200, 1'b1, 1'b1, 0, 1'b0, 4'd0, '0);
      checks++;
      if (got_data.size() != exp_data.size()) begin
         errors++;
         $display("[TB] FAIL stall_len: got %0d bytes expected %0d", got_data.size(), exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_data[i] || got_sob[i] !== exp_sob[i] || got_eob[i] !== exp_eob[i]) begin
            errors++;
            $display("[TB] FAIL stall_byte%0d: got %h/%b/%b expected %h/%b/%b", i,
                     got_data[i], got_sob[i], got_eob[i], exp_data[i], exp_sob[i], exp_eob[i]);
         end
      end
      checks++;
      if (stall_err != 0 || timed_out || done_cnt != 1 || extra_taken != 0) begin
         errors++;
         $display("[TB] FAIL stall_hold: got unstable%0d timeout%0d done%0d extra%0d expected 0 0 1 0",
                  stall_err, timed_out, done_cnt, extra_taken);
      end
      checks++;
      if ({rs_k, rs_n, cc_rate} !== {7'(k_tab[6]), 7'(n_tab[6]), 2'(cc_tab[6])}) begin
         errors++;
         $display("[TB] FAIL stall_cfg: got k%0d n%0d cc%0d expected k%0d n%0d cc%0d",
                  rs_k, rs_n, cc_rate, k_tab[6], n_tab[6], cc_tab[6]);
      end
   endtask

   task automatic test_back_to_back();
      fill_payload(80, 1'b0);
      build_expected(4, 80);
      do_start(4'd4, 11'd80);
      drive_burst(80, 1'b1, 1'b0, 0, 1'b1, 4'd5, 11'd150);
      checks++;
      if (got_data.size() != exp_data.size() || timed_out || done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL b2b_first: got %0d bytes done%0d expected %0d bytes done1",
                  got_data.size(), done_cnt, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_data[i] || got_sob[i] !== exp_sob[i] || got_eob[i] !== exp_eob[i]) begin
            errors++;
            $display("[TB] FAIL b2b_first_byte%0d: got %h/%b/%b expected %h/%b/%b", i,
                     got_data[i], got_sob[i], got_eob[i], exp_data[i], exp_sob[i], exp_eob[i]);
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({busy, err} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL b2b_accept: got busy%b err%b expected 1 0", busy, err);
      end
      fill_payload(150, 1'b0);
      build_expected(5, 150);
      drive_burst(150, 1'b1, 1'b1, 0, 1'b0, 4'd0, '0);
      checks++;
      if (got_data.size() != exp_data.size() || timed_out || done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL b2b_second: got %0d bytes done%0d expected %0d bytes done1",
                  got_data.size(), done_cnt, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_data[i] || got_sob[i] !== exp_sob[i] || got_eob[i] !== exp_eob[i]) begin
            errors++;
            $display("[TB] FAIL b2b_second_byte%0d: got %h/%b/%b expected %h/%b/%b", i,
                     got_data[i], got_sob[i], got_eob[i], exp_data[i], exp_sob[i], exp_eob[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      fill_payload(100, 1'b0);
      do_start(4'd3, 11'd100);
      drive_burst(100, 1'b0, 1'b0, 30, 1'b0, 4'd0, '0);
      reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_sob, out_eob, busy, in_ready, done, err} !== 7'b0 ||
          {out_data, rs_k, rs_n, rs_t, cc_rate} !== 27'b0) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: got %b/%h expected 0/0",
                  {out_valid, out_sob, out_eob, busy, in_ready, done, err},
                  {out_data, rs_k, rs_n, rs_t, cc_rate});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      fill_payload(35, 1'b0);
      build_expected(2, 35);
      do_start(4'd2, 11'd35);
      drive_burst(35, 1'b1, 1'b1, 0, 1'b0, 4'd0, '0);
      checks++;
      if (got_data.size() != exp_data.size() || timed_out || done_cnt != 1) begin
         errors++;
         $display("[TB] FAIL midreset_next: got %0d bytes done%0d expected %0d bytes done1",
                  got_data.size(), done_cnt, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_data[i] || got_sob[i] !== exp_sob[i] || got_eob[i] !== exp_eob[i]) begin
            errors++;
            $display("[TB] FAIL midreset_byte%0d: got %h/%b/%b expected %h/%b/%b", i,
                     got_data[i], got_sob[i], got_eob[i], exp_data[i], exp_sob[i], exp_eob[i]);
         end
      end
      checks++;
      if ({rs_k, rs_t, cc_rate} !== {7'(k_tab[2]), 3'(t_tab[2]), 2'(cc_tab[2])}) begin
         errors++;
         $display("[TB] FAIL midreset_cfg: got k%0d t%0d cc%0d expected k%0d t%0d cc%0d",
                  rs_k, rs_t, cc_rate, k_tab[2], t_tab[2], cc_tab[2]);
      end
   endtask

   initial begin
      test_reset();
      test_rate1();
      test_rate0();
      test_err();
      test_random_stall();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
